// File: rtl/sim_mem_pkg.sv
// rtl/sim_mem_pkg.sv - shared types for the simulation-memory arbiter
package sim_mem_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef enum logic {OWN_I, OWN_D} owner_e;

endpackage

// File: rtl/sim_mem_rr2.sv
// rtl/sim_mem_rr2.sv - two-way round-robin arbiter; prio always points at the last loser
module sim_mem_rr2
  import sim_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  input  logic valid_d,
  input  logic advance,
  output logic grant_i,
  output logic grant_d
);

  owner_e prio_q, prio_d;

  always_comb begin
    grant_i = valid_i & (~valid_d | (prio_q == OWN_I));
    grant_d = valid_d & (~valid_i | (prio_q == OWN_D));
    prio_d  = prio_q;
    if (advance) prio_d = grant_d ? OWN_I : OWN_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= OWN_D;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/sim_mem_arbiter.sv
// rtl/sim_mem_arbiter.sv - shares one memory port between fetch and data requesters
module sim_mem_arbiter
  import sim_mem_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TYPE_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [TYPE_W-1:0] i_req_type,
  output logic              i_resp_valid,
  output logic [XLEN-1:0]   i_resp_rdata,
  output logic              i_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [TYPE_W-1:0] d_req_type,
  input  logic              d_req_wen,
  output logic              d_resp_valid,
  output logic [XLEN-1:0]   d_resp_rdata,
  output logic              d_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [TYPE_W-1:0] mem_type,
  output logic              mem_wen,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              wen_q, wen_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              i_resp_valid_q, i_resp_valid_d;
  logic [XLEN-1:0]   i_resp_rdata_q, i_resp_rdata_d;
  logic              i_resp_err_q, i_resp_err_d;
  logic              d_resp_valid_q, d_resp_valid_d;
  logic [XLEN-1:0]   d_resp_rdata_q, d_resp_rdata_d;
  logic              d_resp_err_q, d_resp_err_d;

  logic grant_i, grant_d, accept_i, accept_d;
  logic finish, timed_out;
  logic [XLEN-1:0] resp_rdata;

  sim_mem_rr2 u_rr2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (i_req_valid),
    .valid_d (d_req_valid),
    .advance (accept_i | accept_d),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Readies are forced low while reset is held so nothing looks accepted.
  assign i_req_ready = rst_n & (state_q == IDLE) & grant_i;
  assign d_req_ready = rst_n & (state_q == IDLE) & grant_d;
  assign accept_i    = i_req_valid & i_req_ready;
  assign accept_d    = d_req_valid & d_req_ready;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    type_d         = type_q;
    wen_d          = wen_q;
    wdog_d         = wdog_q;
    i_resp_valid_d = 1'b0;
    i_resp_rdata_d = '0;
    i_resp_err_d   = 1'b0;
    d_resp_valid_d = 1'b0;
    d_resp_rdata_d = '0;
    d_resp_err_d   = 1'b0;
    finish         = 1'b0;
    timed_out      = 1'b0;
    resp_rdata     = '0;
    unique case (state_q)
      IDLE: begin
        if (accept_d) begin
          owner_d = OWN_D;
          addr_d  = d_req_addr;
          wdata_d = d_req_wdata;
          type_d  = d_req_type;
          wen_d   = d_req_wen;
          state_d = ISSUE;
        end else if (accept_i) begin
          owner_d = OWN_I;
          addr_d  = i_req_addr;
          wdata_d = '0;
          type_d  = i_req_type;
          wen_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          wdog_d  = '0;
        end
      end
      WAIT: begin
        // A response arriving in the expiry cycle still wins over the timeout.
        if (mem_resp_valid) begin
          finish     = 1'b1;
          resp_rdata = mem_resp_rdata;
        end else if (wdog_q == WD_MAX) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
        if (finish) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            i_resp_valid_d = 1'b1;
            i_resp_rdata_d = resp_rdata;
            i_resp_err_d   = timed_out;
          end else begin
            d_resp_valid_d = 1'b1;
            d_resp_rdata_d = resp_rdata;
            d_resp_err_d   = timed_out;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= OWN_I;
      addr_q         <= '0;
      wdata_q        <= '0;
      type_q         <= '0;
      wen_q          <= 1'b0;
      wdog_q         <= '0;
      i_resp_valid_q <= 1'b0;
      i_resp_rdata_q <= '0;
      i_resp_err_q   <= 1'b0;
      d_resp_valid_q <= 1'b0;
      d_resp_rdata_q <= '0;
      d_resp_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      type_q         <= type_d;
      wen_q          <= wen_d;
      wdog_q         <= wdog_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_rdata_q <= i_resp_rdata_d;
      i_resp_err_q   <= i_resp_err_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_rdata_q <= d_resp_rdata_d;
      d_resp_err_q   <= d_resp_err_d;
    end
  end

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_type      = type_q;
  assign mem_wen       = wen_q;
  assign i_resp_valid  = i_resp_valid_q;
  assign i_resp_rdata  = i_resp_rdata_q;
  assign i_resp_err    = i_resp_err_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_resp_rdata  = d_resp_rdata_q;
  assign d_resp_err    = d_resp_err_q;

endmodule

// File: tb/tb_sim_mem_arbiter.sv
// tb/tb_sim_mem_arbiter.sv - directed self-checking bench for sim_mem_arbiter
module tb_sim_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready;
  logic [63:0] i_req_addr, i_req_type;
  logic        i_resp_valid, i_resp_err;
  logic [63:0] i_resp_rdata;
  logic        d_req_valid, d_req_ready, d_req_wen;
  logic [63:0] d_req_addr, d_req_wdata, d_req_type;
  logic        d_resp_valid, d_resp_err;
  logic [63:0] d_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_type, mem_resp_rdata;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int dresp_cnt = 0;
  int base_hs, base_dresp;
  logic exp_d;

  always #5 clk = ~clk;

  sim_mem_arbiter #(.XLEN(64), .TYPE_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
    .i_req_addr(i_req_addr), .i_req_type(i_req_type),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_type(d_req_type), .d_req_wen(d_req_wen),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_wen(mem_wen),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;
    if (d_resp_valid) dresp_cnt <= dresp_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [63:0] rd);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rd;
    tick;
    mem_resp_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {62'd0, i_req_ready, d_req_ready}, 64'd0);
    check({tag, "_resp_valid"}, {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    check({tag, "_err"}, {62'd0, i_resp_err, d_resp_err}, 64'd0);
    check({tag, "_i_rdata"}, i_resp_rdata, 64'd0);
    check({tag, "_d_rdata"}, d_resp_rdata, 64'd0);
    check({tag, "_mem_valid_wen"}, {62'd0, mem_req_valid, mem_wen}, 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_mem_type"}, mem_type, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_req_valid = 0; i_req_addr = 0; i_req_type = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_wdata = 0; d_req_type = 0; d_req_wen = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    repeat (3) tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Fetch only, minimum latency
    d_req_wdata = 64'hFFFF_0000_1234_5678;
    i_req_valid = 1'b1; i_req_addr = 64'h8000_0000; i_req_type = 64'h2;
    #1;
    check("t1_i_ready", {63'd0, i_req_ready}, 64'd1);
    check("t1_d_ready", {63'd0, d_req_ready}, 64'd0);
    tick;
    i_req_valid = 1'b0;
    check("t1_mem_valid", {63'd0, mem_req_valid}, 64'd1);
    check("t1_mem_addr", mem_addr, 64'h8000_0000);
    check("t1_mem_type", mem_type, 64'h2);
    check("t1_mem_wdata", mem_wdata, 64'd0);
    check("t1_mem_wen", {63'd0, mem_wen}, 64'd0);
    serve(64'h13);
    check("t1_i_resp_valid", {63'd0, i_resp_valid}, 64'd1);
    check("t1_i_resp_rdata", i_resp_rdata, 64'h13);
    check("t1_i_resp_err", {63'd0, i_resp_err}, 64'd0);
    check("t1_d_resp_valid", {63'd0, d_resp_valid}, 64'd0);
    tick;
    check("t1_i_resp_pulse", {63'd0, i_resp_valid}, 64'd0);

    // Simultaneous requests held valid: D, I, D, I
    d_req_wdata = 64'd0;
    d_req_addr = 64'h100; i_req_addr = 64'h200;
    d_req_valid = 1'b1; i_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      #1;
      check("t2_d_grant", {63'd0, d_req_ready}, {63'd0, exp_d});
      check("t2_i_grant", {63'd0, i_req_ready}, {63'd0, !exp_d});
      tick;
      check("t2_mem_addr", mem_addr, exp_d ? 64'h100 : 64'h200);
      serve(64'h40 + 64'(k));
      check("t2_d_resp_valid", {63'd0, d_resp_valid}, {63'd0, exp_d});
      check("t2_i_resp_valid", {63'd0, i_resp_valid}, {63'd0, !exp_d});
      check("t2_rdata", exp_d ? d_resp_rdata : i_resp_rdata, 64'h40 + 64'(k));
      if (k == 3) begin
        d_req_valid = 1'b0; i_req_valid = 1'b0;
      end
      tick;
    end

    // Data write with a stalled downstream
    base_hs = hs_cnt; base_dresp = dresp_cnt;
    d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_wdata = 64'hDEAD_BEEF;
    d_req_addr = 64'h300; d_req_type = 64'h3;
    #1;
    check("t3_d_ready", {63'd0, d_req_ready}, 64'd1);
    tick;
    d_req_valid = 1'b0; d_req_wen = 1'b0; d_req_wdata = 64'd0; d_req_addr = 64'd0;
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_valid", {63'd0, mem_req_valid}, 64'd1);
      check("t3_stall_addr", mem_addr, 64'h300);
      check("t3_stall_wdata", mem_wdata, 64'hDEAD_BEEF);
      check("t3_stall_wen_type", {mem_type[62:0], mem_wen}, {63'h3, 1'b1});
      tick;
    end
    mem_req_ready = 1'b1;
    tick;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h55;
    tick;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check("t3_d_resp_valid", {63'd0, d_resp_valid}, 64'd1);
    check("t3_d_resp_rdata", d_resp_rdata, 64'h55);
    check("t3_d_resp_err", {63'd0, d_resp_err}, 64'd0);
    tick; tick;
    check("t3_handshakes", 64'(hs_cnt - base_hs), 64'd1);
    check("t3_resp_pulses", 64'(dresp_cnt - base_dresp), 64'd1);

    // Timeout with TIMEOUT=4, then a late response
    base_dresp = dresp_cnt;
    d_req_valid = 1'b1; d_req_addr = 64'h400;
    tick;
    d_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick;
      check("t4_no_early_resp", {63'd0, d_resp_valid}, 64'd0);
    end
    tick;
    check("t4_d_resp_valid", {63'd0, d_resp_valid}, 64'd1);
    check("t4_d_resp_err", {63'd0, d_resp_err}, 64'd1);
    check("t4_d_resp_rdata", d_resp_rdata, 64'd0);
    tick;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h77;
    tick;
    mem_resp_valid = 1'b0;
    tick; tick;
    check("t4_resp_pulses", 64'(dresp_cnt - base_dresp), 64'd1);
    check("t4_idle_after_late", {63'd0, mem_req_valid}, 64'd0);

    // Reset during WAIT of a data read (which left prio at I)
    d_req_valid = 1'b1; d_req_addr = 64'h600; d_req_type = 64'h1;
    tick;
    d_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    d_req_valid = 1'b1; i_req_valid = 1'b1; i_req_addr = 64'h200;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_in_reset");
    tick;
    rst_n = 1'b1;
    #1;
    check("t5_d_wins_tie", {62'd0, d_req_ready, i_req_ready}, 64'b10);
    tick;
    check("t5_d_mem_addr", mem_addr, 64'h600);
    serve(64'h66);
    check("t5_d_resp", {d_resp_rdata[62:0], d_resp_valid}, {63'h66, 1'b1});
    d_req_valid = 1'b0;
    tick;
    #1;
    check("t5_i_ready", {63'd0, i_req_ready}, 64'd1);
    tick;
    i_req_valid = 1'b0;
    check("t5_i_mem_addr", mem_addr, 64'h200);
    serve(64'h2A);
    check("t5_i_resp_valid", {63'd0, i_resp_valid}, 64'd1);
    check("t5_i_resp_rdata", i_resp_rdata, 64'h2A);
    check("t5_i_resp_err", {63'd0, i_resp_err}, 64'd0);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_mem_arbiter.md
# sim_mem_arbiter

Shares the single-ported simulation memory between the core's instruction-fetch and data-access requesters. The block arbitrates round-robin between the two requesters, issues one transaction at a time on the downstream memory request/response port, and returns the result to the requester that owns it. A watchdog counter covers a downstream that never responds. It sits between the pipeline's fetch/LSU units and the SimMem DPI wrapper.

## Interface
- XLEN, 64: address and data width.
- TYPE_W, 64: width of the access-type/size field, passed through unchanged.
- TIMEOUT, 255: maximum cycles spent in WAIT before an error response; must be at least 1.
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- i_req_valid / i_req_ready  in / out  1: fetch request handshake.
- i_req_addr  in  XLEN: fetch address.
- i_req_type  in  TYPE_W: fetch access type.
- i_resp_valid  out  1: one-cycle fetch response pulse; no backpressure.
- i_resp_rdata  out  XLEN: fetch read data.
- i_resp_err  out  1: set when the fetch response is a timeout error.
- d_req_valid / d_req_ready  in / out  1: data request handshake.
- d_req_addr  in  XLEN: data address.
- d_req_wdata  in  XLEN: data write data.
- d_req_type  in  TYPE_W: data access type.
- d_req_wen  in  1: write enable for the data request.
- d_resp_valid / d_resp_rdata / d_resp_err  out  1 / XLEN / 1: data response, same rules as the fetch response.
- mem_req_valid / mem_req_ready  out / in  1: downstream request handshake.
- mem_addr / mem_wdata / mem_type / mem_wen  out  XLEN / XLEN / TYPE_W / 1: downstream request fields, registered.
- mem_resp_valid  in  1: downstream response strobe.
- mem_resp_rdata  in  XLEN: downstream read data.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - ISSUE: mem_req_valid held until handshake.
  - WAIT: awaiting mem_resp_valid.
  - RESP: return pulse to the owner.
- IDLE grant:
  - Only one requester valid: that requester wins.
  - Both valid: the requester named by the priority pointer `prio` wins. `prio` resets to DATA.
  - After any grant, `prio` points at the loser.
  - The winner's ready is asserted combinationally (ready = IDLE and granted); the loser's ready stays 0.
- On accept, latch into registers: addr, wdata, type, wen and owner. For fetch requests, wen=0 and wdata=0. Go to ISSUE.
- ISSUE:
  - mem_req_valid=1 with the registered fields, stable until mem_req_ready.
  - On mem_req_ready: go to WAIT and clear the watchdog.
- WAIT:
  - On mem_resp_valid: capture rdata, clear err, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT: rdata=0, err=1, go to RESP.
- RESP:
  - Assert the owner's resp_valid for exactly one cycle, with rdata and err; the other side stays 0.
  - Go to IDLE.
- Writes also receive a response; its rdata is whatever the downstream returned.
- mem_resp_valid outside WAIT is ignored. This covers a late response after a timeout.
- Reset (any time, including mid-transaction):
  - State returns to IDLE and the in-flight transaction is abandoned.
  - All outputs are 0: both ready, both resp_valid, both err, mem_req_valid, all mem_* fields and both rdata.
  - Watchdog is 0; `prio` is DATA.

## Timing
- Request accepted in cycle T (valid&ready) → mem_req_valid from T+1.
- With mem_req_ready in T+1 and mem_resp_valid in T+2 → resp_valid in T+3. Minimum latency is 3 cycles.
- One transaction outstanding at a time; no request is accepted from ISSUE through RESP.
- The next grant can occur in the cycle after RESP, so peak throughput is one transaction per 4 cycles.
- Timeout: resp_valid with err arrives TIMEOUT+1 cycles after entering WAIT.
- Watchdog width: clog2(TIMEOUT+1); saturating, no wrap.

## Structure
- Package sim_mem_pkg holds:
  - XLEN default;
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - owner enum {OWN_I, OWN_D}.
- Sub-module sim_mem_rr2: a 2-way round-robin arbiter containing the `prio` flop. Inputs are the two valids and an advance strobe; outputs are the two one-hot grants.
- The FSM, request registers and watchdog stay in the top level.

## Test plan
- Fetch only: i_req addr=0x8000_0000; mem ready immediately; resp one cycle later with rdata=0x13 → i_resp_valid at T+3 with rdata=0x13, err=0, d_resp_valid=0.
- Simultaneous requests, both held valid from reset:
  - Grant order is D, I, D, I.
  - Each requester sees resp_valid only for its own address: D addr=0x100, I addr=0x200.
- Data write, wen=1, wdata=0xDEADBEEF, with mem_req_ready held low for 5 cycles:
  - mem fields stay stable throughout;
  - exactly one handshake occurs;
  - d_resp_valid pulses once.
- Timeout with TIMEOUT=4 and no mem_resp_valid:
  - d_resp_valid arrives 5 cycles after WAIT entry with err=1, rdata=0;
  - a late mem_resp_valid afterwards is ignored, with no second pulse.
- Reset asserted during WAIT:
  - all outputs go to 0 immediately;
  - after release, a new fetch completes normally and D wins the first tie.
